peg_l2_mac_pfc_pause_cntr: RTL
==============================

# peg_l2_mac_pfc_pause_cntr

Multi-class pause timer bank for the L2 MAC transmit path, supporting both 802.3x PAUSE and 802.1Qbb priority flow control (PFC). Per-class timers are loaded from parsed pause/PFC frames and count quanta (512 bit times) scaled to the datapath width. The block drives per-class XOFF status to the TX scheduler and one-cycle expiry pulses to the stats block. It sits between the RX frame parser and the TX arbiter.

## Interface
- BPCLK, 64: bits per clock; power of two in 8..512.
- NUM_CLASSES, 8: number of priority classes; 1..8.
- clk  in  1  MAC clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- pause_en  in  1  config: flow control enable.
- pfc_mode  in  1  config: 1 = PFC per-class; 0 = legacy 802.3x.
- pause_time_valid  in  1  single-cycle strobe from parser.
- pause_class_en  in  NUM_CLASSES  per-class enable vector from the PFC frame.
- pause_time  in  16*NUM_CLASSES  per-class quanta; class c at [16c+15:16c].
- pause_valid  out  NUM_CLASSES  per-class XOFF status.
- pause_any  out  1  OR of pause_valid.
- pause_expired  out  NUM_CLASSES  one-cycle pulse on natural expiry.

## Operation
- SCALE = log2(512/BPCLK); counter width CW = 16+SCALE. Each class holds a CW-bit down-counter.
- Load value for class c = {pause_time[c], SCALE zero bits}. This gives exact quanta timing with no shared prescaler.
- PFC mode (pfc_mode=1): on pause_time_valid, each class with pause_class_en[c]=1 loads its own field. Other classes are untouched.
- Legacy mode (pfc_mode=0): on pause_time_valid, all classes load the class-0 field. pause_class_en is ignored.
- Reload while counting restarts the timer with the new value; values are not accumulated.
- Load of 0 is XON: the timer is cleared immediately and no expiry pulse is generated.
- Counters decrement by 1 per cycle while nonzero. They saturate at 0.
- pause_valid[c] = pause_en & (cntr[c] != 0).
- pause_en low clears all counters on the next edge, ignores loads, and suppresses expiry pulses.
- pause_expired[c] is registered. It is set when cntr[c]==1, no load hits class c that cycle, and pause_en=1.
- Priority per class, highest first: reset, pause_en low, load, decrement.
- Reset: all counters 0. pause_valid, pause_any and pause_expired are 0 in the cycle after reset is sampled low. Reset mid-pause aborts all timers with no expiry pulse.

## Timing
- Strobe in cycle N with load L>0: pause_valid[c] is high in cycles N+1 .. N+L (exactly L cycles).
- With that timing, pause_expired[c] pulses in cycle N+L+1.
- Strobe with L=0 in cycle N: pause_valid[c] is low from cycle N+1.
- pause_en deasserted in cycle N: all pause_valid are low from cycle N+1. pause_en re-asserted starts from idle (0).
- pause_any is combinational from pause_valid; it adds no latency.
- Strobe in the same cycle a counter would expire (cntr==1): the load wins and no expiry pulse is generated.
- pfc_mode and pause_en are quasi-static. A pfc_mode change takes effect on the next strobe only.

## Structure
- Constant PAUSE_QUANTA_BITS=512 and function pause_scale(BPCLK) belong in the shared package peg_l2_mac_pkg. The width CW is derived from them.
- Sub-module peg_l2_mac_pause_timer: one class down-counter plus its expiry register. Ports: clk, rst_n, clr, load, load_val[15:0], pause_valid, pause_expired. Instantiate NUM_CLASSES times via generate.
- The top level holds the mode mux, the load-enable decode and the pause_any OR.
- Elaboration fails if BPCLK is not a power of two within 8..512.

## Test plan
- **PFC single class.** BPCLK=64 (SCALE=3), pfc_mode=1, strobe with class_en=8'h04 and class2 time=5 at cycle 10 -> pause_valid[2] high in cycles 11..50 (40 cycles), pause_expired[2] pulses at 51, other classes stay 0.
- **Legacy broadcast.** pfc_mode=0, class0 time=2, class_en=0 -> all 8 pause_valid high for 16 cycles, 8 simultaneous expiry pulses, pause_any high for 16 cycles.
- **Reload and XON.** Load 100 quanta, reload 1 quanta after 50 cycles -> 8 further cycles then expiry. Separately, load 0 mid-pause -> valid low next cycle, no pulse.
- **Load/expiry collision.** Strobe time=3 in the cycle cntr==1 -> no pulse, valid high for 24 more cycles.
- **Enable and reset.** pause_en dropped mid-pause -> valid low next cycle, no pulse, strobe while disabled ignored. rst_n low mid-pause for 1 cycle -> all outputs 0 next cycle.
- **Width sweep.** BPCLK=512 (SCALE=0), time=16'hFFFF -> valid high exactly 65535 cycles. BPCLK=8, time=1 -> 64 cycles.

Source files
------------

// File: rtl/peg_l2_mac_pkg.sv
// Shared L2 MAC definitions: pause quanta size and datapath-width helpers.
package peg_l2_mac_pkg;

    // One pause quantum is 512 bit times.
    localparam int unsigned PAUSE_QUANTA_BITS = 512;

    // Number of zero bits appended to a quanta count so the timer
    // counts clock cycles: log2(PAUSE_QUANTA_BITS / bpclk).
    function automatic int unsigned pause_scale(input int unsigned bpclk);
        int unsigned s;
        s = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            if ((bpclk << i) == PAUSE_QUANTA_BITS) begin
                s = i;
            end
        end
        return s;
    endfunction

    // Legal datapath widths are powers of two from 8 to 512 bits.
    function automatic bit bpclk_legal(input int unsigned bpclk);
        return (bpclk >= 8) && (bpclk <= PAUSE_QUANTA_BITS) &&
               ((bpclk & (bpclk - 1)) == 0);
    endfunction

endpackage

// File: rtl/peg_l2_mac_pfc_pause_cntr_if.sv
// Parser-to-timer-bank bus: pause frame strobe/fields in, per-class status out.
interface peg_l2_mac_pfc_pause_cntr_if #(
    parameter int unsigned NUM_CLASSES = 8
);
    logic                      pause_time_valid;
    logic [NUM_CLASSES-1:0]    pause_class_en;
    logic [16*NUM_CLASSES-1:0] pause_time;
    logic [NUM_CLASSES-1:0]    pause_valid;
    logic                      pause_any;
    logic [NUM_CLASSES-1:0]    pause_expired;

    // Parser / consumer side.
    modport master (
        output pause_time_valid, pause_class_en, pause_time,
        input  pause_valid, pause_any, pause_expired
    );

    // Timer bank side.
    modport slave (
        input  pause_time_valid, pause_class_en, pause_time,
        output pause_valid, pause_any, pause_expired
    );
endinterface

// File: rtl/peg_l2_mac_pause_timer.sv
// Single-class pause down-counter with registered natural-expiry pulse.
module peg_l2_mac_pause_timer #(
    parameter int unsigned SCALE = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        pause_valid,
    output logic        pause_expired
);
    localparam int unsigned CW = 16 + SCALE;

    logic [CW-1:0] cntr;
    logic [CW-1:0] load_ext;

    // Quanta -> cycles; shift form stays legal when SCALE is 0.
    assign load_ext = CW'(load_val) << SCALE;

    // Counter and expiry register; priority reset, clear, load, decrement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cntr          <= '0;
            pause_expired <= 1'b0;
        end else if (clr) begin
            cntr          <= '0;
            pause_expired <= 1'b0;
        end else if (load) begin
            cntr          <= load_ext;
            pause_expired <= 1'b0;
        end else begin
            if (cntr != '0) begin
                cntr <= cntr - 1'b1;
            end
            pause_expired <= (cntr == CW'(1));
        end
    end

    assign pause_valid = ~clr & (cntr != '0);

endmodule

// File: rtl/peg_l2_mac_pfc_pause_cntr.sv
// PAUSE / PFC timer bank: mode mux, per-class load decode and XOFF summary.
module peg_l2_mac_pfc_pause_cntr
    import peg_l2_mac_pkg::*;
#(
    parameter int unsigned BPCLK       = 64,
    parameter int unsigned NUM_CLASSES = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               pause_en,
    input  logic                               pfc_mode,
    peg_l2_mac_pfc_pause_cntr_if.slave         bus
);
    localparam int unsigned SCALE = pause_scale(BPCLK);

    generate
        if (!bpclk_legal(BPCLK)) begin : g_bad_bpclk
            $error("peg_l2_mac_pfc_pause_cntr: BPCLK must be a power of two in 8..512");
        end
        if (NUM_CLASSES < 1 || NUM_CLASSES > 8) begin : g_bad_classes
            $error("peg_l2_mac_pfc_pause_cntr: NUM_CLASSES must be 1..8");
        end
    endgenerate

    logic [NUM_CLASSES-1:0] load;
    logic [NUM_CLASSES-1:0] valid;
    logic [NUM_CLASSES-1:0] expired;
    logic [15:0]            load_val [NUM_CLASSES];
    logic                   clr;

    assign clr = ~pause_en;

    // Load decode and value mux: PFC uses each class field, legacy broadcasts class 0.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
            load[c]     = 1'b0;
            load_val[c] = bus.pause_time[15:0];
            if (bus.pause_time_valid) begin
                load[c] = pfc_mode ? bus.pause_class_en[c] : 1'b1;
            end
            if (pfc_mode) begin
                load_val[c] = bus.pause_time[16*c +: 16];
            end
        end
    end

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
        peg_l2_mac_pause_timer #(
            .SCALE (SCALE)
        ) u_timer (
            .clk           (clk),
            .rst_n         (rst_n),
            .clr           (clr),
            .load          (load[c]),
            .load_val      (load_val[c]),
            .pause_valid   (valid[c]),
            .pause_expired (expired[c])
        );
    end

    assign bus.pause_valid   = valid;
    assign bus.pause_expired = expired;
    assign bus.pause_any     = |valid;

endmodule
